// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a valid/ready memory port and
// holds one instruction for the decoder until the datapath reports completion.
module instr_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             IMemReq,
   output logic [XLEN-1:0]  IMemAddr,
   input  logic             IMemReady,
   input  logic             IMemRValid,
   input  logic [31:0]      IMemRData,
   output logic [31:0]      Instr,
   output logic [6:0]       Op,
   output logic             InstrValid,
   output logic [XLEN-1:0]  PC,
   output logic [XLEN-1:0]  PCPlus4,
   input  logic             ExecDone,
   input  logic             Branch,
   input  logic             Jump,
   input  logic             Zero,
   input  logic [XLEN-1:0]  PCTarget,
   output logic             Fault,
   output logic [CNT_W-1:0] InstrCount
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_HOLD,
      S_FAULT
   } state_t;

   state_t           r_state;
   logic [XLEN-1:0]  r_pc;
   logic [31:0]      r_instr;
   logic             r_req;
   logic             r_valid;
   logic             r_fault;
   logic [CNT_W-1:0] r_count;

   logic             w_pcSrc;
   logic [XLEN-1:0]  w_pcPlus4;
   logic [XLEN-1:0]  w_nextPc;

   assign w_pcSrc   = (Branch & Zero) | Jump;
   assign w_pcPlus4 = r_pc + XLEN'(4);
   assign w_nextPc  = w_pcSrc ? PCTarget : w_pcPlus4;

   // Outputs are registered alongside the state so they never depend on inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_instr <= '0;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
         r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_FETCH;
               r_req   <= 1'b1;
            end
            S_FETCH: begin
               if (IMemReady) begin
                  r_state <= S_WAIT;
                  r_req   <= 1'b0;
               end
            end
            S_WAIT: begin
               if (IMemRValid) begin
                  r_instr <= IMemRData;
                  r_state <= S_HOLD;
                  r_valid <= 1'b1;
               end
            end
            S_HOLD: begin
               if (ExecDone) begin
                  r_count <= r_count + CNT_W'(1);
                  r_valid <= 1'b0;
                  // A misaligned target freezes the PC at the offending instruction
                  if (w_nextPc[1:0] != 2'b00) begin
                     r_fault <= 1'b1;
                     r_state <= S_FAULT;
                  end else begin
                     r_pc    <= w_nextPc;
                     r_req   <= 1'b1;
                     r_state <= S_FETCH;
                  end
               end
            end
            S_FAULT: begin
               r_state <= S_FAULT;
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign IMemReq    = r_req;
   assign IMemAddr   = r_pc;
   assign Instr      = r_instr;
   assign Op         = r_instr[6:0];
   assign InstrValid = r_valid;
   assign PC         = r_pc;
   assign PCPlus4    = w_pcPlus4;
   assign Fault      = r_fault;
   assign InstrCount = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed bring-up, a table of branch/jump vectors,
// stall and reset corner cases, then randomized traffic against a PC-level model.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemReady = 1'b0;
   logic        IMemRValid = 1'b0;
   logic [31:0] IMemRData = '0;
   logic [31:0] Instr;
   logic [6:0]  Op;
   logic        InstrValid;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        ExecDone = 1'b0;
   logic        Branch = 1'b0;
   logic        Jump = 1'b0;
   logic        Zero = 1'b0;
   logic [31:0] PCTarget = '0;
   logic        Fault;
   logic [31:0] InstrCount;

   int checks = 0;
   int failures = 0;

   logic [31:0] modelPc;
   logic [31:0] modelCount;
   logic        modelFault;

   typedef struct {
      logic        b;
      logic        z;
      logic        j;
      logic [31:0] tgt;
      logic [31:0] expPc;
      logic        expFault;
      string       name;
   } vec_t;

   vec_t vecs[7];

   instr_fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .IMemReq    (IMemReq),
      .IMemAddr   (IMemAddr),
      .IMemReady  (IMemReady),
      .IMemRValid (IMemRValid),
      .IMemRData  (IMemRData),
      .Instr      (Instr),
      .Op         (Op),
      .InstrValid (InstrValid),
      .PC         (PC),
      .PCPlus4    (PCPlus4),
      .ExecDone   (ExecDone),
      .Branch     (Branch),
      .Jump       (Jump),
      .Zero       (Zero),
      .PCTarget   (PCTarget),
      .Fault      (Fault),
      .InstrCount (InstrCount)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Instruction memory contents are a fixed hash of the address
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs;
      IMemReady  = 1'b0;
      IMemRValid = 1'b0;
      IMemRData  = '0;
      ExecDone   = 1'b0;
      Branch     = 1'b0;
      Jump       = 1'b0;
      Zero       = 1'b0;
      PCTarget   = '0;
   endtask

   task automatic applyReset;
      rst_n = 1'b0;
      idleInputs();
      step();
      step();
      checkOutput("rstReq", 32'(IMemReq), 32'd0);
      checkOutput("rstValid", 32'(InstrValid), 32'd0);
      checkOutput("rstFault", 32'(Fault), 32'd0);
      checkOutput("rstCount", InstrCount, 32'd0);
      checkOutput("rstPc", PC, 32'd0);
      checkOutput("rstInstr", Instr, 32'd0);
      rst_n = 1'b1;
      modelPc    = 32'd0;
      modelCount = 32'd0;
      modelFault = 1'b0;
   endtask

   // One memory transaction: optional stall before accept, optional read latency
   task automatic fetchInstr(input int readyDelay, input int rvDelay, input bit noise, output int waited);
      waited = 0;
      while (!IMemReq && waited < 8) begin
         step();
         waited++;
      end
      if (!IMemReq) begin
         checkOutput("reqTimeout", 32'(IMemReq), 32'd1);
         return;
      end
      checkOutput("fetchAddr", IMemAddr, modelPc);
      for (int i = 0; i < readyDelay; i++) begin
         IMemReady = 1'b0;
         if (noise) begin
            IMemRValid = 1'($urandom);
            IMemRData  = $urandom;
            ExecDone   = 1'($urandom);
         end
         step();
         checkOutput("stallReq", 32'(IMemReq), 32'd1);
         checkOutput("stallAddr", IMemAddr, modelPc);
      end
      IMemRValid = 1'b0;
      ExecDone   = 1'b0;
      IMemReady  = 1'b1;
      step();
      IMemReady = 1'b0;
      checkOutput("acceptDrop", 32'(IMemReq), 32'd0);
      for (int i = 0; i < rvDelay; i++) begin
         if (noise) begin
            ExecDone = 1'($urandom);
            Jump     = 1'($urandom);
         end
         step();
         checkOutput("waitValid", 32'(InstrValid), 32'd0);
      end
      ExecDone   = 1'b0;
      Jump       = 1'b0;
      IMemRValid = 1'b1;
      IMemRData  = memWord(modelPc);
      step();
      IMemRValid = 1'b0;
      IMemRData  = $urandom;
      checkOutput("holdValid", 32'(InstrValid), 32'd1);
      checkOutput("holdPc", PC, modelPc);
      checkOutput("holdInstr", Instr, memWord(modelPc));
      checkOutput("holdOp", 32'(Op), 32'(memWord(modelPc) & 32'h7F));
      checkOutput("holdPc4", PCPlus4, modelPc + 32'd4);
   endtask

   task automatic retire(input int holdDelay, input logic b, input logic z, input logic j, input logic [31:0] tgt);
      logic [31:0] nextPc;
      logic [31:0] heldPc;
      heldPc = modelPc;
      for (int i = 0; i < holdDelay; i++) begin
         Branch   = 1'($urandom);
         Jump     = 1'($urandom);
         Zero     = 1'($urandom);
         PCTarget = $urandom;
         step();
         checkOutput("holdStable", PC, heldPc);
         checkOutput("holdStay", 32'(InstrValid), 32'd1);
      end
      Branch   = b;
      Zero     = z;
      Jump     = j;
      PCTarget = tgt;
      ExecDone = 1'b1;
      step();
      idleInputs();
      nextPc = ((b && z) || j) ? tgt : modelPc + 32'd4;
      modelCount = modelCount + 32'd1;
      if (nextPc[1:0] != 2'b00) modelFault = 1'b1;
      else modelPc = nextPc;
      checkOutput("retCount", InstrCount, modelCount);
      checkOutput("retFault", 32'(Fault), 32'(modelFault));
      checkOutput("retValid", 32'(InstrValid), 32'd0);
      checkOutput("retReq", 32'(IMemReq), 32'(!modelFault));
      checkOutput("retPc", PC, modelPc);
   endtask

   task automatic checkFaultSticky(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         IMemReady  = 1'b1;
         IMemRValid = 1'b1;
         IMemRData  = $urandom;
         ExecDone   = 1'b1;
         Jump       = 1'b0;
         step();
         checkOutput("faultSticky", 32'(Fault), 32'd1);
         checkOutput("faultReq", 32'(IMemReq), 32'd0);
         checkOutput("faultValid", 32'(InstrValid), 32'd0);
         checkOutput("faultPc", PC, modelPc);
      end
      idleInputs();
   endtask

   task automatic applyStimulus;
      int w;
      logic b, z, j;
      logic [31:0] tgt;
      int r;

      // Bring-up with the addi x1,x0,5 word from the first fetch
      applyReset();
      IMemReady = 1'b1;
      step();
      checkOutput("bootReq", 32'(IMemReq), 32'd1);
      checkOutput("bootAddr", IMemAddr, 32'd0);
      step();
      IMemReady = 1'b0;
      checkOutput("bootAccept", 32'(IMemReq), 32'd0);
      IMemRValid = 1'b1;
      IMemRData  = 32'h0050_0093;
      step();
      IMemRValid = 1'b0;
      checkOutput("bootValid", 32'(InstrValid), 32'd1);
      checkOutput("bootOp", 32'(Op), 32'h13);
      checkOutput("bootInstr", Instr, 32'h0050_0093);
      checkOutput("bootPc", PC, 32'd0);
      checkOutput("bootPc4", PCPlus4, 32'd4);
      retire(0, 1'b0, 1'b0, 1'b0, 32'd0);
      fetchInstr(0, 0, 1'b0, w);
      checkOutput("spacing4", 32'(w), 32'd0);
      checkOutput("seqAddr4", PC, 32'd4);
      retire(0, 1'b0, 1'b0, 1'b0, 32'd0);
      fetchInstr(0, 0, 1'b0, w);
      checkOutput("spacing8", 32'(w), 32'd0);
      checkOutput("seqAddr8", PC, 32'd8);
      retire(0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("count3", InstrCount, 32'd3);

      // Table of resolved control-flow outcomes at PC=8
      for (int k = 0; k < 7; k++) begin
         applyReset();
         fetchInstr(0, 0, 1'b0, w);
         retire(0, 1'b0, 1'b0, 1'b0, 32'd0);
         fetchInstr(0, 0, 1'b0, w);
         retire(0, 1'b0, 1'b0, 1'b0, 32'd0);
         fetchInstr(0, 0, 1'b0, w);
         retire(1, vecs[k].b, vecs[k].z, vecs[k].j, vecs[k].tgt);
         checkOutput({vecs[k].name, "Pc"}, PC, vecs[k].expPc);
         checkOutput({vecs[k].name, "Fault"}, 32'(Fault), 32'(vecs[k].expFault));
         if (vecs[k].expFault) checkFaultSticky(4);
         else checkOutput({vecs[k].name, "Addr"}, IMemAddr, vecs[k].expPc);
      end

      // Ready withheld for four cycles: request and address must stay put
      applyReset();
      fetchInstr(4, 1, 1'b0, w);
      retire(0, 1'b0, 1'b0, 1'b0, 32'd0);

      // Reset while a read is outstanding, followed by a stale read response
      applyReset();
      fetchInstr(0, 0, 1'b0, w);
      retire(0, 1'b0, 1'b0, 1'b0, 32'd0);
      fetchInstr(0, 0, 1'b0, w);
      retire(0, 1'b0, 1'b0, 1'b0, 32'd0);
      IMemReady = 1'b1;
      step();
      IMemReady = 1'b0;
      checkOutput("midWaitReq", 32'(IMemReq), 32'd0);
      rst_n = 1'b0;
      step();
      checkOutput("midRstInstr", Instr, 32'd0);
      checkOutput("midRstValid", 32'(InstrValid), 32'd0);
      checkOutput("midRstPc", PC, 32'd0);
      rst_n      = 1'b1;
      IMemRValid = 1'b1;
      IMemRData  = 32'hDEAD_BEEF;
      step();
      step();
      IMemRValid = 1'b0;
      checkOutput("staleInstr", Instr, 32'd0);
      checkOutput("staleValid", 32'(InstrValid), 32'd0);
      checkOutput("refetchReq", 32'(IMemReq), 32'd1);
      checkOutput("refetchAddr", IMemAddr, 32'd0);
      modelPc    = 32'd0;
      modelCount = 32'd0;
      modelFault = 1'b0;
      fetchInstr(0, 0, 1'b0, w);
      retire(0, 1'b0, 1'b0, 1'b0, 32'd0);

      // Randomized traffic with noise on ignored inputs
      applyReset();
      for (int n = 0; n < 300; n++) begin
         fetchInstr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, w);
         b = 1'($urandom);
         z = 1'($urandom);
         j = ($urandom_range(0, 3) == 0);
         r = int'($urandom_range(0, 15));
         if (r == 0) tgt = $urandom;
         else if (r == 1) tgt = 32'hFFFF_FFFC;
         else tgt = $urandom & 32'hFFFF_FFFC;
         retire(int'($urandom_range(0, 2)), b, z, j, tgt);
         if (modelFault) begin
            checkFaultSticky(2);
            applyReset();
         end
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0040, 1'b0, "brTaken"};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_000C, 1'b0, "brNotTaken"};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b0, "jump"};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_000C, 1'b0, "zeroOnly"};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h0000_0008, 1'b1, "jumpMisalign"};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0008, 1'b1, "brMisalign"};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, "jumpTop"};
      applyStimulus();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
